// File: rtl/dsc_mul_ctrl.sv
// Operation sequencer for the serial deterministic stochastic-computing multiplier:
// accepts an operand set, runs the multiplier and returns the product over a result handshake.
module dsc_mul_ctrl #(
   parameter int unsigned SNG_WIDTH  = 8,
   parameter int unsigned NUM_INPUTS = 4,
   parameter int unsigned EARLY_EXIT = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NUM_INPUTS*SNG_WIDTH-1:0] in_ops,
   input  logic                            abort,
   output logic [NUM_INPUTS*SNG_WIDTH-1:0] mul_ops,
   output logic                            mul_rst,
   output logic                            mul_en,
   input  logic [NUM_INPUTS*SNG_WIDTH-1:0] mul_z,
   input  logic                            mul_ov,
   output logic                            res_valid,
   input  logic                            res_ready,
   output logic [NUM_INPUTS*SNG_WIDTH-1:0] res_data,
   output logic [NUM_INPUTS*SNG_WIDTH-1:0] res_cycles,
   output logic                            res_skip,
   output logic                            busy
);

   localparam int unsigned W = NUM_INPUTS * SNG_WIDTH;

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

   state_t         state;
   logic [W-1:0]   cyc_cnt;
   logic           any_zero;
   logic           run_exit;

   always_comb begin
      any_zero = 1'b0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
         if (in_ops[i*SNG_WIDTH +: SNG_WIDTH] == '0) any_zero = 1'b1;
      end
   end

   // Terminal count is RUN_LEN-1, i.e. all ones; the counter then wraps to zero.
   // A mul_ov seen on the first RUN cycle is ignored since the multiplier was just cleared.
   always_comb begin
      run_exit = (cyc_cnt == '1);
      if ((EARLY_EXIT != 0) && mul_ov && (cyc_cnt != '0)) run_exit = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         mul_rst    <= 1'b1;
         mul_en     <= 1'b0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_cycles <= '0;
         res_skip   <= 1'b0;
         mul_ops    <= '0;
         cyc_cnt    <= '0;
         busy       <= 1'b0;
      end else if (abort) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         mul_rst   <= 1'b1;
         mul_en    <= 1'b0;
         res_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mul_ops  <= in_ops;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  cyc_cnt  <= '0;
                  if (any_zero) begin
                     res_data   <= '0;
                     res_cycles <= '0;
                     res_skip   <= 1'b1;
                     res_valid  <= 1'b1;
                     state      <= DONE;
                  end else begin
                     state <= CLEAR;
                  end
               end
            end
            CLEAR: begin
               mul_rst <= 1'b0;
               mul_en  <= 1'b1;
               cyc_cnt <= '0;
               state   <= RUN;
            end
            RUN: begin
               cyc_cnt <= cyc_cnt + 1'b1;
               if (run_exit) begin
                  mul_en <= 1'b0;
                  state  <= DRAIN;
               end
            end
            DRAIN: begin
               res_data   <= mul_z;
               res_cycles <= cyc_cnt;
               res_skip   <= 1'b0;
               res_valid  <= 1'b1;
               state      <= DONE;
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  mul_rst   <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
               mul_rst  <= 1'b1;
               mul_en   <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
